// File: rtl/matmul_sched.sv
// Round-robin front end for a matrix_mult unit: two requesters, two
// coefficient banks, one operation in flight, result capture and timeout.
module matmul_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   req0_valid_in,
  input  logic                   req1_valid_in,
  input  logic [3:0][31:0]       req0_vec_in,
  input  logic [3:0][31:0]       req1_vec_in,
  output logic                   req0_ready_out,
  output logic                   req1_ready_out,
  input  logic                   cfg_we_in,
  input  logic                   cfg_sel_in,
  input  logic [1:0]             cfg_row_in,
  input  logic [1:0]             cfg_col_in,
  input  logic [31:0]            cfg_data_in,
  output logic                   cfg_ready_out,
  output logic                   mm_valid_out,
  output logic [3:0][3:0][31:0]  mm_mat_out,
  output logic [3:0][31:0]       mm_vec_out,
  input  logic                   mm_valid_in,
  input  logic [3:0][31:0]       mm_result_in,
  output logic                   res_valid_out,
  output logic                   res_id_out,
  output logic [3:0][31:0]       res_vec_out,
  output logic                   busy_out,
  output logic                   timeout_err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [1:0][3:0][3:0][31:0]  bank_q;
  logic [3:0][31:0]            vec_q;
  logic                        id_q;
  logic                        last_q;
  logic                        res_valid_q;
  logic                        res_id_q;
  logic [3:0][31:0]            res_vec_q;
  logic                        err_q;

  logic                        idle;
  logic                        gnt_en;
  logic                        gnt0;
  logic                        gnt1;
  logic                        hs;
  logic                        cfg_wr;
  logic                        to_hit;

  assign idle   = (state_q == IDLE);
  assign cfg_wr = cfg_we_in && idle;
  // Config writes win over requests; grants are masked while reset is held.
  assign gnt_en = idle && !cfg_we_in && !rst_in;
  assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (gnt_en) begin
      if (req0_valid_in && req1_valid_in) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid_in;
        gnt1 = req1_valid_in;
      end
    end
  end

  assign hs = (gnt0 && req0_valid_in) || (gnt1 && req1_valid_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bank_q <= '0;
    end else if (cfg_wr) begin
      bank_q[cfg_sel_in][cfg_row_in][cfg_col_in] <= cfg_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_vec_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            vec_q   <= gnt1 ? req1_vec_in : req0_vec_in;
            id_q    <= gnt1;
            last_q  <= gnt1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mm_valid_in) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q;
            res_vec_q   <= mm_result_in;
            state_q     <= IDLE;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready_out  = gnt0;
  assign req1_ready_out  = gnt1;
  assign cfg_ready_out   = idle;
  assign mm_valid_out    = (state_q == ISSUE);
  assign mm_mat_out      = bank_q[id_q];
  assign mm_vec_out      = vec_q;
  assign res_valid_out   = res_valid_q;
  assign res_id_out      = res_id_q;
  assign res_vec_out     = res_vec_q;
  assign busy_out        = !idle;
  assign timeout_err_out = err_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: transaction-level reference model, emulated
// matrix_mult, directed corner sequences and randomized traffic.
module tb_matmul_sched;

  localparam int TO = 64;

  typedef logic [3:0][31:0]      vec_t;
  typedef logic [3:0][3:0][31:0] mat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic v0 = 0, v1 = 0;
  vec_t vec0 = '0, vec1 = '0;
  logic r0, r1;
  logic cfg_we = 0, cfg_sel = 0;
  logic [1:0] cfg_row = 0, cfg_col = 0;
  logic [31:0] cfg_data = 0;
  logic cfg_rdy;
  logic mmv_o;
  mat_t mm_mat;
  vec_t mm_vec;
  logic mmv_i = 0;
  vec_t mm_res = '0;
  logic resv, resid;
  vec_t resvec;
  logic busy, terr;

  matmul_sched #(.TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst),
    .req0_valid_in(v0), .req1_valid_in(v1),
    .req0_vec_in(vec0), .req1_vec_in(vec1),
    .req0_ready_out(r0), .req1_ready_out(r1),
    .cfg_we_in(cfg_we), .cfg_sel_in(cfg_sel),
    .cfg_row_in(cfg_row), .cfg_col_in(cfg_col),
    .cfg_data_in(cfg_data), .cfg_ready_out(cfg_rdy),
    .mm_valid_out(mmv_o), .mm_mat_out(mm_mat),
    .mm_vec_out(mm_vec), .mm_valid_in(mmv_i),
    .mm_result_in(mm_res), .res_valid_out(resv),
    .res_id_out(resid), .res_vec_out(resvec),
    .busy_out(busy), .timeout_err_out(terr)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  logic [31:0] rb [2][4][4];
  bit   m_idle, m_last, m_err, m_id, m_res_id;
  vec_t m_vec, m_res_vec, pend;
  int   m_issue, m_wake, m_res, m_errc, m_mm_at;
  bit   mm_en = 1, spur_en = 0, mon_en = 0;
  int   mm_lat = 4;
  int   hs_cyc, hs_id, res_cyc;
  vec_t res_seen;

  task automatic chk_b(string nm, logic a, logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b cyc %0d", nm, a, e, cyc);
    end
  endtask

  task automatic chk_i(string nm, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d cyc %0d", nm, a, e, cyc);
    end
  endtask

  task automatic chk_v(string nm, vec_t a, vec_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h cyc %0d", nm, a, e, cyc);
    end
  endtask

  task automatic chk_m(string nm, mat_t a, mat_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h cyc %0d", nm, a, e, cyc);
    end
  endtask

  task automatic bound_fail(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired cyc %0d", nm, cyc);
  endtask

  function automatic mat_t bank_p(bit k);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = rb[k][r][c];
    return m;
  endfunction

  function automatic vec_t mul(bit k, vec_t v);
    vec_t o;
    for (int r = 0; r < 4; r++) begin
      o[r] = 0;
      for (int c = 0; c < 4; c++)
        o[r] += rb[k][r][c] * v[c];
    end
    return o;
  endfunction

  function automatic vec_t mkv(int a, int b, int c, int d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  function automatic vec_t rndv();
    vec_t v;
    for (int i = 0; i < 4; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          rb[k][r][c] = 0;
    m_idle = 1; m_last = 1; m_err = 0; m_id = 0;
    m_vec = '0; m_issue = -100; m_wake = -1;
    m_res = -1; m_errc = -1; m_mm_at = -1;
    hs_cyc = -1; res_cyc = -1;
  endtask

  // Transaction-level expectations evaluated once per cycle.
  task automatic monitor();
    bit e0, e1, pref1;
    int k;
    if (cyc == m_wake) m_idle = 1;
    if (cyc == m_errc) m_err = 1;
    chk_b("busy", busy, !m_idle);
    chk_b("cfg_ready", cfg_rdy, m_idle);
    chk_b("mm_valid", mmv_o, cyc == m_issue);
    chk_b("res_valid", resv, cyc == m_res);
    chk_b("timeout_err", terr, m_err);
    if (cyc == m_res) begin
      chk_b("res_id", resid, m_res_id);
      chk_v("res_vec", resvec, m_res_vec);
    end
    if (resv) begin
      res_cyc = cyc;
      res_seen = resvec;
    end
    if (cyc == m_issue) begin
      chk_v("mm_vec", mm_vec, m_vec);
      chk_m("mm_mat", mm_mat, bank_p(m_id));
      pend = mul(m_id, m_vec);
      if (mm_en) m_mm_at = cyc + mm_lat;
    end
    e0 = 0; e1 = 0;
    if (m_idle && !cfg_we) begin
      if (v0 && v1) begin
        pref1 = (m_last == 0);
        e0 = !pref1;
        e1 = pref1;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk_b("req0_ready", r0, e0);
    chk_b("req1_ready", r1, e1);
    if (v0 && r0) begin hs_cyc = cyc; hs_id = 0; end
    if (v1 && r1) begin hs_cyc = cyc; hs_id = 1; end
    if (m_idle && cfg_we) begin
      rb[cfg_sel][cfg_row][cfg_col] = cfg_data;
    end else if ((e0 && v0) || (e1 && v1)) begin
      m_id = e1;
      m_last = e1;
      m_vec = e1 ? vec1 : vec0;
      m_idle = 0;
      m_issue = cyc + 1;
    end
    if (!m_idle && cyc > m_issue) begin
      k = cyc - m_issue;
      if (mmv_i) begin
        m_wake = cyc + 1;
        m_res = cyc + 1;
        m_res_vec = mm_res;
        m_res_id = m_id;
      end else if (k == TO) begin
        m_wake = cyc + 1;
        m_errc = cyc + 1;
      end
    end
  endtask

  // Emulated matrix_mult plus optional stray result pulses.
  task automatic mm_drive();
    mmv_i = 0;
    if (cyc == m_mm_at) begin
      mmv_i = 1;
      mm_res = pend;
    end else if (spur_en && $urandom_range(7) == 0) begin
      mmv_i = 1;
      mm_res = rndv();
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    cyc++;
    mm_drive();
  endtask

  task automatic idle_in();
    v0 = 0; v1 = 0; cfg_we = 0;
  endtask

  task automatic do_reset();
    v0 = 1; v1 = 1; cfg_we = 0;
    rst = 1;
    #1;
    chk_b("rst_busy", busy, 0);
    chk_b("rst_mmv", mmv_o, 0);
    chk_b("rst_resv", resv, 0);
    chk_b("rst_resid", resid, 0);
    chk_v("rst_resvec", resvec, '0);
    chk_b("rst_err", terr, 0);
    chk_m("rst_mat", mm_mat, '0);
    chk_v("rst_vec", mm_vec, '0);
    chk_b("rst_r0", r0, 0);
    chk_b("rst_r1", r1, 0);
    mon_en = 0;
    model_reset();
    step();
    step();
    idle_in();
    rst = 0;
    mon_en = 1;
  endtask

  task automatic cfg_wr(bit s, int r, int c, logic [31:0] d);
    cfg_we = 1; cfg_sel = s;
    cfg_row = r[1:0]; cfg_col = c[1:0]; cfg_data = d;
    step();
    cfg_we = 0;
  endtask

  task automatic wait_hs(string nm);
    int i;
    hs_cyc = -1;
    for (i = 0; i < TO + 40 && hs_cyc < 0; i++) step();
    if (hs_cyc < 0) bound_fail(nm);
  endtask

  task automatic wait_idle(string nm);
    int i;
    for (i = 0; i < TO + 40 && !m_idle; i++) step();
    if (!m_idle) bound_fail(nm);
  endtask

  task automatic req(bit k, vec_t v, string nm);
    if (k) begin v1 = 1; vec1 = v; end
    else begin v0 = 1; vec0 = v; end
    wait_hs(nm);
    v0 = 0; v1 = 0;
  endtask

  typedef struct {
    bit v0;
    bit v1;
    bit exp_id;
  } rr_t;

  rr_t tbl[9];
  int  got[4];

  initial begin
    tbl = '{
      '{1, 0, 0}, '{0, 1, 1}, '{1, 1, 0},
      '{1, 1, 1}, '{1, 1, 0}, '{0, 1, 1},
      '{1, 1, 0}, '{1, 0, 0}, '{1, 1, 1}
    };
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Both requesters held valid: grants alternate starting with req0.
    mm_lat = 2;
    v0 = 1; v1 = 1; vec0 = rndv(); vec1 = rndv();
    for (int g = 0; g < 4; g++) begin
      wait_hs("rr_hold_hs");
      got[g] = hs_id;
    end
    idle_in();
    for (int g = 0; g < 4; g++) chk_i("rr_hold", got[g], g % 2);
    wait_idle("rr_hold_idle");

    do_reset();

    // Identity in bank 0, latency 4 -> result 6 cycles after handshake.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cfg_wr(0, r, c, (r == c) ? 32'd1 : 32'd0);
    mm_lat = 4;
    res_cyc = -1;
    req(0, mkv(1, 1, 1, 1), "ident_hs");
    wait_idle("ident_idle");
    chk_i("ident_lat", res_cyc - hs_cyc, 6);
    chk_v("ident_vec", res_seen, mkv(1, 1, 1, 1));
    chk_b("ident_id", resid, 0);

    // Config write and request together: config wins, grant next cycle.
    cfg_we = 1; cfg_sel = 0; cfg_row = 0; cfg_col = 0; cfg_data = 3;
    v0 = 1; vec0 = mkv(2, 0, 0, 0);
    hs_cyc = -1;
    step();
    chk_i("cfgprio_nohs", hs_cyc, -1);
    cfg_we = 0;
    step();
    chk_i("cfgprio_hs", hs_cyc, cyc - 1);
    v0 = 0;
    wait_idle("cfgprio_idle");
    chk_v("cfgprio_vec", res_seen, mkv(6, 0, 0, 0));

    // Arbitration table, one full transaction per row.
    foreach (tbl[i]) begin
      mm_lat = 1 + (i % 5);
      v0 = tbl[i].v0; v1 = tbl[i].v1;
      vec0 = rndv(); vec1 = rndv();
      wait_hs("tbl_hs");
      idle_in();
      chk_i("tbl_grant", hs_id, tbl[i].exp_id);
      wait_idle("tbl_idle");
    end

    // Randomized traffic, config writes and stray result pulses.
    spur_en = 1;
    for (int i = 0; i < 600; i++) begin
      cfg_we = ($urandom_range(3) == 0);
      cfg_sel = $urandom_range(1);
      cfg_row = 2'($urandom_range(3));
      cfg_col = 2'($urandom_range(3));
      cfg_data = $urandom_range(15);
      v0 = $urandom_range(1);
      v1 = $urandom_range(1);
      vec0 = rndv(); vec1 = rndv();
      mm_lat = $urandom_range(1, 8);
      step();
    end
    idle_in();
    spur_en = 0;
    wait_idle("rand_idle");
    step();
    step();

    // No result ever arrives: timeout, sticky flag, next request served.
    mm_en = 0;
    res_cyc = -1;
    req(1, rndv(), "to_hs");
    wait_idle("to_idle");
    chk_i("to_nores", res_cyc, -1);
    chk_b("to_flag", terr, 1);
    mm_en = 1;
    mm_lat = 3;
    req(0, rndv(), "to_next_hs");
    wait_idle("to_next_idle");
    chk_b("to_next_res", res_cyc > hs_cyc, 1);
    chk_b("to_sticky", terr, 1);

    // Reset mid-WAIT, then a late result pulse must be ignored.
    mm_en = 0;
    req(0, rndv(), "rw_hs");
    step();
    step();
    step();
    chk_b("rw_busy", busy, 1);
    do_reset();
    mmv_i = 1;
    mm_res = rndv();
    step();
    step();
    chk_i("rw_late", res_cyc, -1);
    mm_en = 1;
    mm_lat = 2;
    req(0, mkv(5, 6, 7, 8), "rw_zero_hs");
    wait_idle("rw_zero_idle");
    chk_v("rw_zero", res_seen, '0);
    chk_b("rw_err", terr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
